nmcu_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single `mem` port among the NUM_NMCUS `sync_nmcu` instances inside `nmcu_ctrl`. It holds a grant for one complete memory transaction, from `sel` until `ready`, then inserts one release cycle and rotates priority. This gives starvation-free access and a clean `sel` edge to the memory model on every transaction. The bidirectional `data_bus` tristate stays in `nmcu_ctrl`; this block sees split read and write data.

---
 rtl/nmcu_pkg.sv | 13 +
 rtl/rr_pick.sv | 26 ++
 rtl/nmcu_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_nmcu_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmcu_pkg.sv
// rtl/nmcu_pkg.sv - shared types and widths for the NMCU memory arbiter
package nmcu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int NMCU_ADDR_W = 16;
    localparam int NMCU_DATA_W = 32;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set bit of req & ~mask at or after ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  onehot,
    output logic          valid
);

    logic [N-1:0]   eligible;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] base;
    logic [2*N-1:0] hit;

    assign eligible = req & ~mask;
    assign dbl      = {eligible, eligible};
    assign base     = {{(2*N-1){1'b0}}, 1'b1} << ptr;
    // The subtraction borrows up to the first set bit at or above ptr; the upper copy handles wrap.
    assign hit      = dbl & ~(dbl - base);
    assign onehot   = hit[N-1:0] | hit[2*N-1:N];
    assign valid    = |eligible;

endmodule

// File: rtl/nmcu_mem_arbiter.sv
// rtl/nmcu_mem_arbiter.sv - round-robin owner of the shared mem port for the sync_nmcu instances
// Optional counters stat_xfers/stat_wait when NMCU_ARB_STATS_EN is defined.
module nmcu_mem_arbiter
    import nmcu_pkg::*;
#(
    parameter int NUM_NMCUS     = 4,
    parameter int ADDR_WIDTH    = NMCU_ADDR_W,
    parameter int DATABUS_WIDTH = NMCU_DATA_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_NMCUS-1:0]               req_sel,
    input  logic [NUM_NMCUS-1:0]               req_w,
    input  logic [NUM_NMCUS*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_NMCUS*DATABUS_WIDTH-1:0] req_wdata,
    output logic [NUM_NMCUS-1:0]               req_ready,
    output logic [DATABUS_WIDTH-1:0]           req_rdata,
    output logic [NUM_NMCUS-1:0]               grant,
    output logic                               mem_sel,
    output logic                               mem_w,
    output logic [ADDR_WIDTH-1:0]              address_bus,
    output logic [DATABUS_WIDTH-1:0]           mem_wdata,
    input  logic [DATABUS_WIDTH-1:0]           mem_rdata,
`ifdef NMCU_ARB_STATS_EN
    output logic [31:0]                        stat_xfers,
    output logic [31:0]                        stat_wait,
`endif
    input  logic                               ready
);

    localparam int PW = (NUM_NMCUS > 1) ? $clog2(NUM_NMCUS) : 1;

    arb_state_t           state, state_next;
    logic [NUM_NMCUS-1:0] grant_next;
    logic [NUM_NMCUS-1:0] last, last_next;
    logic [PW-1:0]        ptr, ptr_next;
    logic [PW-1:0]        g_idx;
    logic [PW-1:0]        adv_ptr;
    logic [NUM_NMCUS-1:0] pick_mask;
    logic [NUM_NMCUS-1:0] pick_onehot;
    logic                 pick_valid;

    // The just-served requester sits out the release cycle so it cannot be double-served.
    assign pick_mask = (state == RELEASE) ? last : '0;

    rr_pick #(
        .N  (NUM_NMCUS),
        .PW (PW)
    ) u_pick (
        .req    (req_sel),
        .ptr    (ptr),
        .mask   (pick_mask),
        .onehot (pick_onehot),
        .valid  (pick_valid)
    );

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < NUM_NMCUS; k++) begin
            if (grant[k]) g_idx = PW'(k);
        end
    end

    assign adv_ptr = (g_idx == PW'(NUM_NMCUS - 1)) ? '0 : g_idx + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            last  <= last_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        ptr_next   = ptr;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_onehot;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Completion wins over a same-cycle drop; either way the owner is released.
                if (ready || ((req_sel & grant) == '0)) begin
                    if (ready) req_ready = grant;
                    last_next  = grant;
                    ptr_next   = adv_ptr;
                    grant_next = '0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (pick_valid) begin
                    grant_next = pick_onehot;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_w       = 1'b0;
        address_bus = '0;
        mem_wdata   = '0;
        if (state == BUSY) begin
            for (int k = 0; k < NUM_NMCUS; k++) begin
                if (grant[k]) begin
                    mem_w       = req_w[k];
                    address_bus = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata   = req_wdata[k*DATABUS_WIDTH +: DATABUS_WIDTH];
                end
            end
        end
    end

    assign mem_sel   = (state == BUSY);
    assign req_rdata = rst ? '0 : mem_rdata;

`ifdef NMCU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_xfers <= '0;
            stat_wait  <= '0;
        end else begin
            if ((|req_ready) && (stat_xfers != '1)) stat_xfers <= stat_xfers + 32'd1;
            if ((|(req_sel & ~grant)) && (stat_wait != '1)) stat_wait <= stat_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nmcu_mem_arbiter.sv
// tb/tb_nmcu_mem_arbiter.sv - directed and randomized checks of nmcu_mem_arbiter against an integer model
module tb_nmcu_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_sel = '0;
    logic [N-1:0]    req_w = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   req_rdata;
    logic [N-1:0]    grant;
    logic            mem_sel;
    logic            mem_w;
    logic [AW-1:0]   address_bus;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = 32'hA5A5_A5A5;
    logic            ready = 1'b0;
`ifdef NMCU_ARB_STATS_EN
    logic [31:0]     stat_xfers;
    logic [31:0]     stat_wait;
    int              m_xfers, m_wait;
`endif

    nmcu_mem_arbiter #(.NUM_NMCUS(N), .ADDR_WIDTH(AW), .DATABUS_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_sel     (req_sel),
        .req_w       (req_w),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .req_rdata   (req_rdata),
        .grant       (grant),
        .mem_sel     (mem_sel),
        .mem_w       (mem_w),
        .address_bus (address_bus),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
`ifdef NMCU_ARB_STATS_EN
        .stat_xfers  (stat_xfers),
        .stat_wait   (stat_wait),
`endif
        .ready       (ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rand_mode = 0;
    int mem_lat = 1;
    logic [N-1:0] pend = '0;
    logic [N-1:0] done_prev = '0;
    logic [31:0] mem [logic [15:0]];
    int order[$];
    bit sel_hist[$];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memread(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic int scan(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Memory: ready arrives L cycles after the first cycle mem_sel is seen.
    int mcnt = 0, cur_lat = 1;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            mcnt = 0;
            ready = 1'b0;
        end else if (mem_sel) begin
            mcnt++;
            if (mcnt == 1) cur_lat = rand_mode ? int'($urandom_range(1, 3)) : mem_lat;
            if (mcnt == cur_lat + 1) begin
                ready = 1'b1;
                if (mem_w) begin
                    mem[address_bus] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = memread(address_bus);
                end
            end else begin
                ready = 1'b0;
                mem_rdata = rand_mode ? $urandom : 32'hA5A5_A5A5;
            end
        end else begin
            mcnt = 0;
            ready = rand_mode && ($urandom_range(0, 7) == 0);
            mem_rdata = rand_mode ? $urandom : 32'hA5A5_A5A5;
        end
    end

    // Reference model: phase 0 idle, 1 serving m_owner, 2 release.
    int m_phase = 0, m_owner = -1, m_ptr = 0, m_last = 0, m_pick;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_owner = -1; m_ptr = 0; m_last = 0;
`ifdef NMCU_ARB_STATS_EN
            m_xfers = 0; m_wait = 0;
`endif
        end else begin
`ifdef NMCU_ARB_STATS_EN
            if ((m_owner < 0 && req_sel != 0) || (m_owner >= 0 && (req_sel & ~(4'b1 << m_owner)) != 0))
                m_wait++;
`endif
            if (m_phase == 0) begin
                m_pick = scan(req_sel, m_ptr);
                if (m_pick >= 0) begin m_owner = m_pick; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (ready || !req_sel[m_owner]) begin
`ifdef NMCU_ARB_STATS_EN
                    if (ready) m_xfers++;
`endif
                    m_last = m_owner;
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                    m_phase = 2;
                end
            end else begin
                m_pick = scan(req_sel & ~(4'b1 << m_last), m_ptr);
                if (m_pick >= 0) begin m_owner = m_pick; m_phase = 1; end
                else m_phase = 0;
            end
        end
    end

    logic [N-1:0]  e_grant, e_rr;
    logic          e_w;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    always @(negedge clk) begin
        if (!rst) begin
            e_grant = '0; e_rr = '0; e_w = 1'b0; e_addr = '0; e_wd = '0;
            if (m_phase == 1) begin
                e_grant = 4'b1 << m_owner;
                e_w     = req_w[m_owner];
                e_addr  = req_addr[m_owner*AW +: AW];
                e_wd    = req_wdata[m_owner*DW +: DW];
                if (ready) e_rr = e_grant;
            end
            cmp("grant", grant, e_grant);
            cmp("mem_sel", mem_sel, m_phase == 1);
            cmp("mem_w", mem_w, e_w);
            cmp("address_bus", address_bus, e_addr);
            cmp("mem_wdata", mem_wdata, e_wd);
            cmp("req_ready", req_ready, e_rr);
            cmp("req_rdata", req_rdata, mem_rdata);
            if (e_rr != 0 && !e_w) cmp("rdata_vs_mem", req_rdata, memread(e_addr));
            if (rand_mode) begin
                for (int k = 0; k < N; k++) begin
                    if (req_ready[k]) cmp("ready_has_pending_txn", pend[k], 1'b1);
                end
            end
`ifdef NMCU_ARB_STATS_EN
            cmp("stat_xfers", stat_xfers, m_xfers);
            cmp("stat_wait", stat_wait, m_wait);
`endif
            done_prev = req_ready;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        rand_mode = 0;
        req_sel = '0; req_w = '0; pend = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic set_txn(input int k, input logic w, input logic [15:0] a, input logic [31:0] d);
        req_w[k] = w;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    // Serve from req_sel until ntx completions; keep=1 re-presents immediately, else the bit drops.
    task automatic serve(input int ntx, input bit keep);
        int got;
        order.delete();
        sel_hist.delete();
        for (int c = 0; c < 200 && order.size() < ntx; c++) begin
            @(negedge clk);
            sel_hist.push_back(mem_sel);
            got = -1;
            for (int k = 0; k < N; k++) if (req_ready[k]) got = k;
            if (got >= 0) order.push_back(got);
            @(posedge clk);
            #2;
            if (got >= 0 && !keep) req_sel[got] = 1'b0;
        end
        if (order.size() < ntx) cmp("serve_timeout", order.size(), ntx);
    endtask

    initial begin
        int first_done;
        int exp_fair[12];

        do_reset();
        mem_lat = 1;
        mem[16'h0100] = 32'd7;
        @(negedge clk);
        cmp("rst_grant", grant, 4'b0000);
        cmp("rst_mem_sel", mem_sel, 1'b0);
        cmp("rst_req_ready", req_ready, 4'b0000);
        cmp("rst_address_bus", address_bus, 16'h0);
        cmp("idle_rdata_passthrough", req_rdata, 32'hA5A5_A5A5);

        // Single read by requester 0 at 0x0100, L=1.
        @(posedge clk); #2;
        set_txn(0, 1'b0, 16'h0100, 32'h0);
        req_sel = 4'b0001;
        @(negedge clk);
        cmp("single_T_sel", mem_sel, 1'b0);
        @(negedge clk);
        cmp("single_T1_sel", mem_sel, 1'b1);
        cmp("single_T1_addr", address_bus, 16'h0100);
        cmp("single_T1_ready", req_ready, 4'b0000);
        @(negedge clk);
        cmp("single_T2_sel", mem_sel, 1'b1);
        cmp("single_T2_ready", req_ready, 4'b0001);
        cmp("single_T2_rdata", req_rdata, 32'd7);
        @(posedge clk); #2;
        req_sel = 4'b0000;
        @(negedge clk);
        cmp("single_T3_sel", mem_sel, 1'b0);
        cmp("single_T3_grant", grant, 4'b0000);

        // Simultaneous 0101 from reset: 0 then 2 with one low cycle between.
        do_reset();
        set_txn(0, 1'b0, 16'h0100, 32'h0);
        set_txn(2, 1'b0, 16'h0102, 32'h0);
        req_sel = 4'b0101;
        serve(2, 1'b0);
        if (order.size() == 2) begin
            cmp("simul_first", order[0], 0);
            cmp("simul_second", order[1], 2);
        end
        first_done = -1;
        for (int i = 0; i < sel_hist.size(); i++) begin
            if (first_done < 0 && i >= 2 && sel_hist[i] && sel_hist[i-1] && !sel_hist[i+1 < sel_hist.size() ? i+1 : i]) first_done = i;
        end
        if (first_done >= 0 && first_done + 2 < sel_hist.size()) begin
            cmp("simul_gap_low", sel_hist[first_done+1], 1'b0);
            cmp("simul_gap_resume", sel_hist[first_done+2], 1'b1);
        end else begin
            cmp("simul_gap_found", first_done >= 0, 1'b1);
        end
`ifdef NMCU_ARB_STATS_EN
        cmp("stats_xfers_lit", stat_xfers, 32'd2);
        cmp("stats_wait_lit", stat_wait, 32'd4);
`endif

        // Fairness: all four continuously pending.
        do_reset();
        for (int k = 0; k < N; k++) set_txn(k, 1'b0, 16'h0100 + 16'(k), 32'h0);
        req_sel = 4'b1111;
        serve(12, 1'b1);
        exp_fair = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 12 && i < order.size(); i++) cmp($sformatf("fair_%0d", i), order[i], exp_fair[i]);
        req_sel = '0;

        // Write passthrough from requester 3.
        do_reset();
        set_txn(3, 1'b1, 16'h0207, 32'hDEAD_BEEF);
        req_sel = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        cmp("wr_mem_w", mem_w, 1'b1);
        cmp("wr_addr", address_bus, 16'h0207);
        cmp("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        cmp("wr_grant", grant, 4'b1000);
        serve(1, 1'b0);
        cmp("wr_mem_contents", memread(16'h0207), 32'hDEAD_BEEF);

        // Abort by requester 1: no completion, pointer moves to 2.
        do_reset();
        mem_lat = 4;
        set_txn(1, 1'b0, 16'h0110, 32'h0);
        set_txn(0, 1'b0, 16'h0100, 32'h0);
        set_txn(2, 1'b0, 16'h0102, 32'h0);
        req_sel = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        cmp("abort_grant1", grant, 4'b0010);
        @(posedge clk); #2;
        req_sel = 4'b0000;
        @(negedge clk);
        cmp("abort_no_ready", req_ready, 4'b0000);
        @(posedge clk); #2;
        req_sel = 4'b0101;
        @(negedge clk);
        cmp("abort_release_sel", mem_sel, 1'b0);
        cmp("abort_release_ready", req_ready, 4'b0000);
        @(negedge clk);
        cmp("abort_ptr_is_2", grant, 4'b0100);

        // Reset in the middle of a transaction.
        do_reset();
        mem_lat = 3;
        req_sel = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        cmp("rstbusy_sel_before", mem_sel, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        cmp("rstbusy_sel", mem_sel, 1'b0);
        cmp("rstbusy_grant", grant, 4'b0000);
        cmp("rstbusy_ready", req_ready, 4'b0000);
        cmp("rstbusy_rdata", req_rdata, 32'h0);
        cmp("rstbusy_addr", address_bus, 16'h0);
        cmp("rstbusy_wdata", mem_wdata, 32'h0);
        cmp("rstbusy_w", mem_w, 1'b0);

        // Randomized traffic with aborts, varying latency and stray ready pulses.
        do_reset();
        rand_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            for (int k = 0; k < N; k++) begin
                if (pend[k]) begin
                    if (done_prev[k]) begin
                        pend[k] = 1'b0;
                        if ($urandom_range(0, 1) == 1) begin
                            set_txn(k, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)), $urandom);
                            pend[k] = 1'b1;
                        end
                    end else if (grant[k] && !ready && $urandom_range(0, 39) == 0) begin
                        pend[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    set_txn(k, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)), $urandom);
                    pend[k] = 1'b1;
                end
            end
            req_sel = pend;
        end
        req_sel = '0;
        pend = '0;
        repeat (10) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
